// File: rtl/uart_rx_top.sv
// UART receiver: oversampled start detection, 3-sample majority bit decisions,
// LSB-first deserialisation with optional parity and stop-bit checking.
module uart_rx_top #(
    parameter int FRAME_WIDTH    = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      par_en,
    input  logic                      PAR_TYP,
    output logic [FRAME_WIDTH-1:0]    P_DATA,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      rx_busy
);
    localparam int BCW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
    logic [BCW-1:0]            bit_q, bit_d;
    logic [FRAME_WIDTH-1:0]    shift_q, shift_d;
    logic [2:0]                smp_q, smp_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      par_flag_q, par_flag_d;
    logic [FRAME_WIDTH-1:0]    pdata_q, pdata_d;
    logic                      dv_q, dv_d;
    logic                      perr_q, perr_d;
    logic                      serr_q, serr_d;
    logic                      busy_q, busy_d;

    logic [PRESCALE_WIDTH-1:0] half_s;
    logic                      last_edge_s;
    logic                      bit_s;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    function automatic logic frame_parity(input logic [FRAME_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign half_s      = prescale >> 1;
    assign last_edge_s = (edge_q == (prescale - PRESCALE_WIDTH'(1)));
    assign bit_s       = majority3(smp_q);

    // Next-state logic: edge counter, majority sampler, frame FSM and strobes.
    always_comb begin
        state_d    = state_q;
        edge_d     = edge_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        smp_d      = smp_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_flag_d = par_flag_q;
        pdata_d    = pdata_q;
        dv_d       = 1'b0;
        perr_d     = 1'b0;
        serr_d     = 1'b0;

        // Three samples straddle mid-bit; the vote is stable from half+2 onward.
        if (state_q != IDLE) begin
            edge_d = last_edge_s ? {PRESCALE_WIDTH{1'b0}} : (edge_q + PRESCALE_WIDTH'(1));
            if (edge_q == (half_s - PRESCALE_WIDTH'(1))) begin
                smp_d[0] = RX_IN;
            end else if (edge_q == half_s) begin
                smp_d[1] = RX_IN;
            end else if (edge_q == (half_s + PRESCALE_WIDTH'(1))) begin
                smp_d[2] = RX_IN;
            end else begin
                smp_d = smp_q;
            end
        end else begin
            edge_d = {PRESCALE_WIDTH{1'b0}};
        end

        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d    = START;
                    edge_d     = PRESCALE_WIDTH'(1);
                    par_en_d   = par_en;
                    par_typ_d  = PAR_TYP;
                    par_flag_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (last_edge_s) begin
                    if (bit_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        bit_d   = {BCW{1'b0}};
                    end
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (last_edge_s) begin
                    shift_d                = shift_q >> 1;
                    shift_d[FRAME_WIDTH-1] = bit_s;
                    bit_d                  = bit_q + BCW'(1);
                    if (bit_q == BCW'(FRAME_WIDTH - 1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        state_d = DATA;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (last_edge_s) begin
                    par_flag_d = bit_s ^ frame_parity(shift_q, par_typ_q);
                    state_d    = STOP;
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (last_edge_s) begin
                    serr_d  = ~bit_s;
                    perr_d  = par_flag_q;
                    dv_d    = bit_s & ~par_flag_q;
                    state_d = IDLE;
                    if (bit_s & ~par_flag_q) begin
                        pdata_d = shift_q;
                    end else begin
                        pdata_d = pdata_q;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            edge_q     <= {PRESCALE_WIDTH{1'b0}};
            bit_q      <= {BCW{1'b0}};
            shift_q    <= {FRAME_WIDTH{1'b0}};
            smp_q      <= 3'b000;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_flag_q <= 1'b0;
            pdata_q    <= {FRAME_WIDTH{1'b0}};
            dv_q       <= 1'b0;
            perr_q     <= 1'b0;
            serr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_q     <= edge_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            smp_q      <= smp_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            par_flag_q <= par_flag_d;
            pdata_q    <= pdata_d;
            dv_q       <= dv_d;
            perr_q     <= perr_d;
            serr_q     <= serr_d;
            busy_q     <= busy_d;
        end
    end

    assign P_DATA     = pdata_q;
    assign data_valid = dv_q;
    assign par_err    = perr_q;
    assign stp_err    = serr_q;
    assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: frame-level timeline model compared every
// cycle, plus literal expectations at hand-computed cycles.
module tb_uart_rx_top;
    localparam int FW   = 8;
    localparam int PW   = 6;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          reset;
    logic          RX_IN;
    logic [PW-1:0] prescale;
    logic          par_en;
    logic          PAR_TYP;
    logic [FW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    logic          rx_busy;

    uart_rx_top #(.FRAME_WIDTH(FW), .PRESCALE_WIDTH(PW)) dut (
        .clk        (clk),
        .reset      (reset),
        .RX_IN      (RX_IN),
        .prescale   (prescale),
        .par_en     (par_en),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle timeline filled in by the frame model.
    bit         exp_busy [0:MAXC-1];
    bit         exp_dv   [0:MAXC-1];
    bit         exp_pe   [0:MAXC-1];
    bit         exp_se   [0:MAXC-1];
    bit         exp_rst  [0:MAXC-1];
    logic [7:0] exp_data [0:MAXC-1];
    logic [7:0] m_pdata = 8'h00;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        int          at;
        int          sig;
        logic [31:0] val;
        string       nm;
    } lit_t;
    lit_t lits[$];

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (int'(a) + int'(b) + int'(c)) >= 2;
    endfunction

    function automatic logic [31:0] sig_val(input int s);
        case (s)
            0:       return 32'(data_valid);
            1:       return 32'(par_err);
            2:       return 32'(stp_err);
            3:       return 32'(rx_busy);
            default: return 32'(P_DATA);
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", nm, cyc, act, req);
        end
    endtask

    task automatic expect_at(input int at, input string nm, input int sig, input logic [31:0] v);
        lit_t l;
        l.at  = at;
        l.sig = sig;
        l.val = v;
        l.nm  = nm;
        lits.push_back(l);
    endtask

    // Single compare process: model timeline every cycle, then literal expectations.
    always @(negedge clk) begin : cmp
        if (chk_en && cyc < MAXC) begin
            if (exp_rst[cyc]) m_pdata = 8'h00;
            if (exp_dv[cyc])  m_pdata = exp_data[cyc];
            check("data_valid", 32'(data_valid), 32'(exp_dv[cyc]));
            check("par_err",    32'(par_err),    32'(exp_pe[cyc]));
            check("stp_err",    32'(stp_err),    32'(exp_se[cyc]));
            check("rx_busy",    32'(rx_busy),    32'(exp_busy[cyc]));
            check("P_DATA",     32'(P_DATA),     32'(m_pdata));
            while (lits.size() > 0 && lits[0].at <= cyc) begin
                if (lits[0].at < cyc) check({lits[0].nm, "_missed"}, 32'(cyc), 32'(lits[0].at));
                else check(lits[0].nm, sig_val(lits[0].sig), lits[0].val);
                void'(lits.pop_front());
            end
        end
    end

    task automatic idle(input int k);
        RX_IN = 1'b1;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Builds the line waveform, derives the expected outcome from the bit decisions,
    // schedules it on the timeline, then drives the line one cycle at a time.
    task automatic send_frame(input int p, input logic [7:0] d, input logic pe, input logic pt,
                              input logic pbit, input logic sbit, input int start_low,
                              input int glitch_edge, input int abort_at);
        logic       ln [0:511];
        logic       dec [0:10];
        logic       v;
        logic [7:0] md;
        logic       perr;
        logic       serr;
        int         n;
        int         c0;
        int         len;
        int         ones;
        n        = pe ? 11 : 10;
        c0       = cyc;
        prescale = p[PW-1:0];
        par_en   = pe;
        PAR_TYP  = pt;
        for (int b = 0; b < n; b++) begin
            if (b == 0)            v = 1'b0;
            else if (b <= 8)       v = d[b-1];
            else if (pe && b == 9) v = pbit;
            else                   v = sbit;
            for (int e = 0; e < p; e++) begin
                if (b == 0 && e >= start_low)                    ln[b*p+e] = 1'b1;
                else if (b >= 1 && b <= 8 && e == glitch_edge)   ln[b*p+e] = ~v;
                else                                             ln[b*p+e] = v;
            end
        end
        for (int b = 0; b < n; b++)
            dec[b] = maj3(ln[b*p+p/2-1], ln[b*p+p/2], ln[b*p+p/2+1]);
        ones = 0;
        md   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            md[i] = dec[i+1];
            ones += int'(dec[i+1]);
        end
        serr = ~dec[n-1];
        perr = 1'b0;
        if (pe) perr = (((ones % 2) == 1) ^ pt) != dec[9];

        if (dec[0])             len = p;
        else if (abort_at >= 0) len = abort_at + 1;
        else                    len = n * p;
        for (int k = 1; k < len; k++) exp_busy[c0+k] = 1'b1;
        if (!dec[0] && abort_at >= 0) begin
            exp_rst[c0+len] = 1'b1;
        end else if (!dec[0]) begin
            exp_dv[c0+len]   = ~(serr | perr);
            exp_pe[c0+len]   = perr;
            exp_se[c0+len]   = serr;
            exp_data[c0+len] = md;
        end

        for (int r = 0; r < len; r++) begin
            RX_IN = ln[r];
            reset = (r == abort_at);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        int c0;
        reset    = 1'b1;
        RX_IN    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        PAR_TYP  = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        expect_at(cyc, "reset_dv",    0, 32'd0);
        expect_at(cyc, "reset_busy",  3, 32'd0);
        expect_at(cyc, "reset_pdata", 4, 32'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);

        // Good frame, even parity.
        c0 = cyc;
        expect_at(c0 + 87, "t1_busy_last", 3, 32'd1);
        expect_at(c0 + 88, "t1_dv",        0, 32'd1);
        expect_at(c0 + 88, "t1_perr",      1, 32'd0);
        expect_at(c0 + 88, "t1_pdata",     4, 32'hA5);
        expect_at(c0 + 88, "t1_busy_off",  3, 32'd0);
        expect_at(c0 + 89, "t1_dv_once",   0, 32'd0);
        send_frame(8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 8, -1, -1);
        idle(3);

        // Parity error: odd parity expected, bit 0 sent.
        c0 = cyc;
        expect_at(c0 + 88, "t2_perr",  1, 32'd1);
        expect_at(c0 + 88, "t2_dv",    0, 32'd0);
        expect_at(c0 + 88, "t2_pdata", 4, 32'hA5);
        send_frame(8, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8, -1, -1);
        idle(3);

        // Stop error with the line held low: a new frame starts immediately.
        c0 = cyc;
        expect_at(c0 + 160, "t3_serr",    2, 32'd1);
        expect_at(c0 + 160, "t3_dv",      0, 32'd0);
        expect_at(c0 + 160, "t3_pdata",   4, 32'hA5);
        expect_at(c0 + 161, "t3_restart", 3, 32'd1);
        expect_at(c0 + 320, "t3b_dv",     0, 32'd1);
        expect_at(c0 + 320, "t3b_pdata",  4, 32'hC3);
        send_frame(16, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 16, -1, -1);
        send_frame(16, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 16, -1, -1);
        idle(5);

        // Start glitch: two low cycles only.
        c0 = cyc;
        expect_at(c0 + 1, "gl_busy1", 3, 32'd1);
        expect_at(c0 + 7, "gl_busy7", 3, 32'd1);
        expect_at(c0 + 8, "gl_busy8", 3, 32'd0);
        expect_at(c0 + 8, "gl_dv",    0, 32'd0);
        send_frame(8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 2, -1, -1);
        idle(5);

        // Majority vote masks a one-cycle inversion at edge 15 of every data bit.
        c0 = cyc;
        expect_at(c0 + 320, "maj_dv",    0, 32'd1);
        expect_at(c0 + 320, "maj_pdata", 4, 32'h81);
        send_frame(32, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 32, 15, -1);
        idle(5);

        // Reset during data bit 4, then a clean frame.
        c0 = cyc;
        expect_at(c0 + 89, "rst_busy",  3, 32'd0);
        expect_at(c0 + 89, "rst_dv",    0, 32'd0);
        expect_at(c0 + 89, "rst_pdata", 4, 32'h00);
        send_frame(16, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 16, -1, 88);
        idle(3);
        c0 = cyc;
        expect_at(c0 + 160, "post_rst_dv",    0, 32'd1);
        expect_at(c0 + 160, "post_rst_pdata", 4, 32'h5A);
        send_frame(16, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 16, -1, -1);
        idle(2);

        // Back-to-back frames with no idle gap.
        c0 = cyc;
        expect_at(c0 + 88,  "b2b_dv1",    0, 32'd1);
        expect_at(c0 + 88,  "b2b_pdata1", 4, 32'h0F);
        expect_at(c0 + 89,  "b2b_busy",   3, 32'd1);
        expect_at(c0 + 168, "b2b_dv2",    0, 32'd1);
        expect_at(c0 + 168, "b2b_pdata2", 4, 32'hF0);
        send_frame(8, 8'h0F, 1'b1, 1'b1, 1'b1, 1'b1, 8, -1, -1);
        send_frame(8, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 8, -1, -1);

        // Parity and stop errors together.
        c0 = cyc;
        expect_at(c0 + 88, "both_perr",  1, 32'd1);
        expect_at(c0 + 88, "both_serr",  2, 32'd1);
        expect_at(c0 + 88, "both_dv",    0, 32'd0);
        expect_at(c0 + 88, "both_pdata", 4, 32'hF0);
        send_frame(8, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 8, -1, -1);
        idle(5);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
